// File: rtl/matrix_scan_sequencer_if.sv
// rtl/matrix_scan_sequencer_if.sv - scan request, matrix read and checker strobe bundle
//
// Purpose: groups every non-clock/reset signal of matrix_scan_sequencer.
//   master : the sequencer (drives reads, checker strobes, results, busy/done)
//   slave  : the game FSM, matrix storage and the two checkers
// Signals:
//   start, mode                         scan request from the game FSM
//   busy, done                          scan status back to the game FSM
//   rd_en, rd_col, rd_row               matrix storage read port
//   matrix_tile_valid, tile_col/row     qualifier/position of returned tile data
//   vert_tile, next_row, accumulate_row row-boundary strobes for the full-row checker
//   reset_collisions                    clear strobe for the collision checker
//   reset_matrix_full_check             clear strobe for the full-row checker
//   collision_occurred                  sticky flag from the collision checker
//   matrix_has_full_row, full_row_index verdict from the full-row checker
//   result_*                            captured verdicts
interface matrix_scan_sequencer_if;
  logic       start;
  logic       mode;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [3:0] rd_col;
  logic [5:0] rd_row;
  logic       matrix_tile_valid;
  logic [3:0] tile_col;
  logic [5:0] tile_row;
  logic [5:0] vert_tile;
  logic       next_row;
  logic       accumulate_row;
  logic       reset_collisions;
  logic       reset_matrix_full_check;
  logic       collision_occurred;
  logic       matrix_has_full_row;
  logic [5:0] full_row_index;
  logic       result_collision;
  logic       result_full_row;
  logic [5:0] result_row_index;

  modport master (
    input  start, mode, collision_occurred, matrix_has_full_row, full_row_index,
    output busy, done, rd_en, rd_col, rd_row, matrix_tile_valid, tile_col, tile_row,
           vert_tile, next_row, accumulate_row, reset_collisions,
           reset_matrix_full_check, result_collision, result_full_row, result_row_index
  );

  modport slave (
    output start, mode, collision_occurred, matrix_has_full_row, full_row_index,
    input  busy, done, rd_en, rd_col, rd_row, matrix_tile_valid, tile_col, tile_row,
           vert_tile, next_row, accumulate_row, reset_collisions,
           reset_matrix_full_check, result_collision, result_full_row, result_row_index
  );
endinterface

// File: rtl/matrix_scan_sequencer.sv
// rtl/matrix_scan_sequencer.sv - one-pass playfield scan driving the collision and full-row checkers
//
// Purpose: on start, clears both checkers, reads every tile row by row (one-cycle
// read latency), emits tile-valid / row-boundary strobes, then captures the
// checker verdicts into result registers and pulses done.
// Ports:
//   clk    clock, all state on rising edge
//   reset  asynchronous active-high reset; forces IDLE and zeroes all outputs
//   bus    matrix_scan_sequencer_if.master (request, read port, checker strobes, results)
// Parameters:
//   WIDTH  columns per row (1..16), HEIGHT rows (1..64)
module matrix_scan_sequencer #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 22
) (
  input  logic                    clk,
  input  logic                    reset,
  matrix_scan_sequencer_if.master bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] SCAN    = 3'd2;
  localparam logic [2:0] GAP     = 3'd3;
  localparam logic [2:0] ROW_END = 3'd4;
  localparam logic [2:0] DRAIN   = 3'd5;
  localparam logic [2:0] FINISH  = 3'd6;

  localparam logic [3:0] LAST_COL = 4'(WIDTH - 1);
  localparam logic [5:0] LAST_ROW = 6'(HEIGHT - 1);

  logic [2:0] state;
  logic [3:0] col_q;
  logic [5:0] row_q;
  logic       mode_q;
  logic       done_q;
  logic       tile_valid_q;
  logic [3:0] tile_col_q;
  logic [5:0] tile_row_q;
  logic       res_collision_q;
  logic       res_full_row_q;
  logic [5:0] res_row_index_q;

  logic scanning;
  logic early_exit;
  logic rd_en_w;
  logic row_strobe;

  // Collision mode abandons the pass as soon as the checker reports a hit;
  // that cycle must neither read nor close a row.
  assign scanning   = (state == SCAN) || (state == GAP) || (state == ROW_END);
  assign early_exit = scanning && !mode_q && bus.collision_occurred;
  assign rd_en_w    = (state == SCAN) && !early_exit;
  // CLEAR also pulses next_row (without accumulate) to arm the checker for row 0.
  assign row_strobe = (state == CLEAR) || ((state == ROW_END) && !early_exit);

  assign bus.busy                    = (state != IDLE);
  assign bus.done                    = done_q;
  assign bus.rd_en                   = rd_en_w;
  assign bus.rd_col                  = col_q;
  assign bus.rd_row                  = row_q;
  assign bus.matrix_tile_valid       = tile_valid_q;
  assign bus.tile_col                = tile_col_q;
  assign bus.tile_row                = tile_row_q;
  assign bus.vert_tile               = row_q;
  assign bus.next_row                = row_strobe;
  assign bus.accumulate_row          = (state == ROW_END) && !early_exit && mode_q;
  assign bus.reset_collisions        = (state == CLEAR);
  assign bus.reset_matrix_full_check = (state == CLEAR);
  assign bus.result_collision        = res_collision_q;
  assign bus.result_full_row         = res_full_row_q;
  assign bus.result_row_index        = res_row_index_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      col_q           <= 4'd0;
      row_q           <= 6'd0;
      mode_q          <= 1'b0;
      done_q          <= 1'b0;
      tile_valid_q    <= 1'b0;
      tile_col_q      <= 4'd0;
      tile_row_q      <= 6'd0;
      res_collision_q <= 1'b0;
      res_full_row_q  <= 1'b0;
      res_row_index_q <= 6'd0;
    end else begin
      done_q       <= 1'b0;
      tile_valid_q <= rd_en_w;
      // Tile position follows the read by one cycle and holds while invalid.
      if (rd_en_w) begin
        tile_col_q <= col_q;
        tile_row_q <= row_q;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          col_q <= 4'd0;
          row_q <= 6'd0;
          state <= SCAN;
        end
        SCAN: begin
          if (early_exit) begin
            state <= DRAIN;
          end else if (col_q == LAST_COL) begin
            state <= GAP;
          end else begin
            col_q <= col_q + 4'd1;
          end
        end
        // GAP lets the row's last tile land before the row boundary strobe.
        GAP: begin
          state <= early_exit ? DRAIN : ROW_END;
        end
        ROW_END: begin
          if (early_exit) begin
            state <= DRAIN;
          end else if (row_q == LAST_ROW) begin
            state <= FINISH;
          end else begin
            row_q <= row_q + 6'd1;
            col_q <= 4'd0;
            state <= SCAN;
          end
        end
        DRAIN: begin
          state <= FINISH;
        end
        FINISH: begin
          res_collision_q <= bus.collision_occurred;
          res_full_row_q  <= bus.matrix_has_full_row;
          res_row_index_q <= bus.full_row_index;
          done_q          <= 1'b1;
          state           <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
